read_fsm: RTL and testbench

- Single-word SRAM read sequencer; the read-side counterpart of the controller's write sequencer.
- On a `start` pulse it latches an address and drives the SRAM address, chip-select and output-enable for a fixed access window.
- It samples the SRAM data bus, presents the word on `read_data` and pulses `done`.
- Sits between the controller's arbitration logic and the SRAM pins, sharing the address/CS lines with the write sequencer through an external mux.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/read_fsm_if.sv | 30 +++
 rtl/read_fsm.sv | 146 ++++++++++++++
 tb/tb_read_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller sequencers (read and write side):
// default bus widths, the sequencer state encoding and the wait-counter width.
package sram_ctrl_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 16;

   // Wait counter width; covers WAIT_STATES 0..15 without wrapping.
   localparam int CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Terminal count for the access window, sized to the wait counter.
   function automatic logic [CNT_WIDTH-1:0] last_count(input int wait_states);
      return CNT_WIDTH'(wait_states);
   endfunction

endpackage

// File: rtl/read_fsm_if.sv
// Request and SRAM pin bundle of the read sequencer.
// slave: seen from the sequencer; master: seen from the controller/SRAM side.
interface read_fsm_if
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] input_address;
   logic [DATA_WIDTH-1:0] sram_data;
   logic [ADDR_WIDTH-1:0] sram_address;
   logic                  sram_cs;
   logic                  sram_oe;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  busy;
   logic                  done;

   modport slave (
      input  start, input_address, sram_data,
      output sram_address, sram_cs, sram_oe, read_data, busy, done
   );

   modport master (
      output start, input_address, sram_data,
      input  sram_address, sram_cs, sram_oe, read_data, busy, done
   );

endinterface

// File: rtl/read_fsm.sv
// Single-word SRAM read sequencer. A start accepted in IDLE latches the
// address, holds CS/OE for WAIT_STATES+1 cycles, captures the data bus,
// then pulses done for one cycle with read_data valid. All outputs are
// registered; reset is synchronous and active-high.
// Optional macro READ_SYNC_INPUT_EN: sram_data goes through an input
// register and the access window grows by one cycle.
module read_fsm
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int WAIT_STATES = 2
) (
   input logic       clk,
   input logic       reset,
   read_fsm_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = last_count(WAIT_STATES);

   state_t                state_r,  state_next_s;
   logic [CNT_WIDTH-1:0]  count_r,  count_next_s;
   logic [ADDR_WIDTH-1:0] addr_r,   addr_next_s;
   logic                  cs_r,     cs_next_s;
   logic                  oe_r,     oe_next_s;
   logic [DATA_WIDTH-1:0] rdata_r,  rdata_next_s;
   logic                  busy_r,   busy_next_s;
   logic                  done_r,   done_next_s;

`ifdef READ_SYNC_INPUT_EN
   logic [DATA_WIDTH-1:0] data_sync_r;
   logic                  sample_r, sample_next_s;

   // Input register on the SRAM data bus; capture uses this copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_sync_r <= DATA_WIDTH'(0);
      end else begin
         data_sync_r <= bus.sram_data;
      end
   end
`endif

   // State and registered-output update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         count_r  <= CNT_WIDTH'(0);
         addr_r   <= ADDR_WIDTH'(0);
         cs_r     <= 1'b0;
         oe_r     <= 1'b0;
         rdata_r  <= DATA_WIDTH'(0);
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
`ifdef READ_SYNC_INPUT_EN
         sample_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_next_s;
         count_r  <= count_next_s;
         addr_r   <= addr_next_s;
         cs_r     <= cs_next_s;
         oe_r     <= oe_next_s;
         rdata_r  <= rdata_next_s;
         busy_r   <= busy_next_s;
         done_r   <= done_next_s;
`ifdef READ_SYNC_INPUT_EN
         sample_r <= sample_next_s;
`endif
      end
   end

   // Next-state and next-output decode; everything holds unless changed.
   always_comb begin
      state_next_s  = state_r;
      count_next_s  = count_r;
      addr_next_s   = addr_r;
      cs_next_s     = cs_r;
      oe_next_s     = oe_r;
      rdata_next_s  = rdata_r;
      busy_next_s   = busy_r;
      done_next_s   = 1'b0;
`ifdef READ_SYNC_INPUT_EN
      sample_next_s = sample_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               addr_next_s  = bus.input_address;
               cs_next_s    = 1'b1;
               oe_next_s    = 1'b1;
               busy_next_s  = 1'b1;
               count_next_s = CNT_WIDTH'(0);
               state_next_s = ACCESS;
            end else begin
               state_next_s = IDLE;
            end
         end
         ACCESS: begin
`ifdef READ_SYNC_INPUT_EN
            // Extra cycle lets the registered copy of the last sampled word settle.
            if (sample_r) begin
               rdata_next_s  = data_sync_r;
               done_next_s   = 1'b1;
               cs_next_s     = 1'b0;
               oe_next_s     = 1'b0;
               sample_next_s = 1'b0;
               state_next_s  = DONE;
            end else if (count_r == LAST_CNT) begin
               sample_next_s = 1'b1;
            end else begin
               count_next_s = count_r + CNT_WIDTH'(1);
            end
`else
            if (count_r == LAST_CNT) begin
               rdata_next_s = bus.sram_data;
               done_next_s  = 1'b1;
               cs_next_s    = 1'b0;
               oe_next_s    = 1'b0;
               state_next_s = DONE;
            end else begin
               count_next_s = count_r + CNT_WIDTH'(1);
            end
`endif
         end
         DONE: begin
            busy_next_s  = 1'b0;
            state_next_s = IDLE;
         end
         default: begin
            cs_next_s    = 1'b0;
            oe_next_s    = 1'b0;
            busy_next_s  = 1'b0;
            state_next_s = IDLE;
         end
      endcase
   end

   assign bus.sram_address = addr_r;
   assign bus.sram_cs      = cs_r;
   assign bus.sram_oe      = oe_r;
   assign bus.read_data    = rdata_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;

endmodule

// File: tb/tb_read_fsm.sv
// Bench for read_fsm: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
// Expected read words and their due cycles are queued at stimulus time and
// a monitor checks them whenever done is presented.
module tb_read_fsm;

`ifdef READ_SYNC_INPUT_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int W2 = 2;
   localparam int W0 = 0;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_pass;
   exp_t q2[$];
   exp_t q0[$];

   read_fsm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus2 ();
   read_fsm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus0 ();

   read_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(W2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));
   read_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(W0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave));

   function automatic logic [15:0] mem(input logic [15:0] a);
      case (a)
         16'd100: return 16'd10;
         16'd200: return 16'd20;
         16'd5:   return 16'hBEEF;
         default: return a ^ 16'h5A5A;
      endcase
   endfunction

   // SRAM model: drives data only while selected and output-enabled.
   assign bus2.sram_data = (bus2.sram_cs && bus2.sram_oe) ? mem(bus2.sram_address) : 16'h0000;
   assign bus0.sram_data = (bus0.sram_cs && bus0.sram_oe) ? mem(bus0.sram_address) : 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   // Monitor: compare each done pulse against the oldest expected read.
   always @(negedge clk) begin
      if (bus2.done === 1'b1) begin
         if (q2.size() == 0) check("dut2_spurious_done", 1, 0);
         else begin
            exp_t e;
            e = q2.pop_front();
            check("dut2_read_data", bus2.read_data, e.data);
            check("dut2_done_cycle", cyc, e.due);
         end
      end
      if (bus0.done === 1'b1) begin
         if (q0.size() == 0) check("dut0_spurious_done", 1, 0);
         else begin
            exp_t e;
            e = q0.pop_front();
            check("dut0_read_data", bus0.read_data, e.data);
            check("dut0_done_cycle", cyc, e.due);
         end
      end
   end

   // Watch dut2 for ncyc falling edges, optionally dropping start after the
   // first and changing the address at index chg_at.
   task automatic observe2(input int ncyc, input logic [15:0] exp_addr, input bit drop_start,
                           input int chg_at, input logic [15:0] chg_addr,
                           output int cs_cnt, output int addr_bad,
                           output int done_idx, output int idle_idx);
      cs_cnt = 0; addr_bad = 0; done_idx = -1; idle_idx = -1;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (bus2.sram_cs) begin
            cs_cnt++;
            if (bus2.sram_address != exp_addr) addr_bad++;
         end
         if (bus2.done && done_idx < 0) done_idx = i;
         if (!bus2.busy && done_idx >= 0 && idle_idx < 0) idle_idx = i;
         if (drop_start) bus2.start = 1'b0;
         if (i == chg_at) bus2.input_address = chg_addr;
      end
   endtask

   initial begin
      int cs_cnt, addr_bad, done_idx, idle_idx, done_cnt;
      exp_t e;
      cyc = 0; n_checks = 0; n_pass = 0;
      reset = 1'b1;
      bus2.start = 1'b0; bus2.input_address = 16'd0;
      bus0.start = 1'b0; bus0.input_address = 16'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset: everything low.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs", {bus2.sram_cs, bus2.sram_oe, bus2.done, bus2.busy, bus2.read_data}, 20'd0);
      end

      // Basic read of address 100.
      bus2.input_address = 16'd100; bus2.start = 1'b1;
      e.data = 16'd10; e.due = cyc + W2 + 2 + EXTRA; q2.push_back(e);
      observe2(8, 16'd100, 1'b1, -1, 16'd0, cs_cnt, addr_bad, done_idx, idle_idx);
      check("basic_cs_cycles", cs_cnt, W2 + 1 + EXTRA);
      check("basic_addr", addr_bad, 0);
      check("basic_done_idx", done_idx, W2 + 1 + EXTRA);
      check("basic_busy_drop", idle_idx, done_idx + 1);

      // start held high, address moved to 200 mid-access.
      bus2.input_address = 16'd100; bus2.start = 1'b1;
      e.data = 16'd10; e.due = cyc + W2 + 2 + EXTRA; q2.push_back(e);
      observe2(W2 + 2 + EXTRA, 16'd100, 1'b0, 1, 16'd200, cs_cnt, addr_bad, done_idx, idle_idx);
      check("hold_cs_cycles", cs_cnt, W2 + 1 + EXTRA);
      check("hold_addr", addr_bad, 0);
      check("hold_done_idx", done_idx, W2 + 1 + EXTRA);
      @(negedge clk);
      check("hold_back_idle", {bus2.busy, bus2.sram_cs}, 2'b00);
      e.data = 16'd20; e.due = cyc + W2 + 2 + EXTRA; q2.push_back(e);
      @(negedge clk);
      check("hold_restart_busy", bus2.busy, 1);
      check("hold_restart_addr", bus2.sram_address, 200);
      bus2.start = 1'b0;
      repeat (W2 + 4 + EXTRA) @(negedge clk);

      // WAIT_STATES=0 instance, address 5.
      bus0.input_address = 16'd5; bus0.start = 1'b1;
      e.data = 16'hBEEF; e.due = cyc + W0 + 2 + EXTRA; q0.push_back(e);
      cs_cnt = 0; done_idx = -1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus0.sram_cs) cs_cnt++;
         if (bus0.done && done_idx < 0) done_idx = i;
         bus0.start = 1'b0;
      end
      check("ws0_cs_cycles", cs_cnt, W0 + 1 + EXTRA);
      check("ws0_done_idx", done_idx, W0 + 1 + EXTRA);

      // Reset during the second ACCESS cycle, with a coincident start.
      bus2.input_address = 16'd100; bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      @(negedge clk);
      reset = 1'b1; bus2.start = 1'b1;
      @(negedge clk);
      reset = 1'b0; bus2.start = 1'b0;
      check("rst_cs", bus2.sram_cs, 0);
      check("rst_busy", bus2.busy, 0);
      check("rst_read_data", bus2.read_data, 0);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus2.done || bus2.busy) done_cnt++;
      end
      check("rst_no_activity", done_cnt, 0);

      check("q2_drained", q2.size(), 0);
      check("q0_drained", q0.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
